// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA timing generator.
// Default timing is 640x480@60 with an 8-bit {R3,G3,B2} pixel.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam int unsigned CNT_W = 10;
  localparam int unsigned RGB_W = 8;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [RGB_W-1:0] rgb_t;

  localparam rgb_t BORDER_RGB = 8'h1c;

  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping 0..TOTAL-1 counter with enable, terminal count and a window compare.
// cnt_nxt exposes the value the counter takes on the coming edge.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned TOTAL  = 800,
  parameter int unsigned WIN_LO = 656,
  parameter int unsigned WIN_HI = 751
) (
  input  logic             clk_div,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             tc,
  output logic             in_win
);

  localparam cnt_t LAST = cnt_t'(TOTAL - 1);
  localparam cnt_t LO   = cnt_t'(WIN_LO);
  localparam cnt_t HI   = cnt_t'(WIN_HI);

  assign tc     = (cnt == LAST);
  assign in_win = (cnt >= LO) && (cnt <= HI);

  always_comb begin
    cnt_nxt = cnt;
    if (en) cnt_nxt = tc ? '0 : cnt + CNT_W'(1);
  end

  always_ff @(posedge clk_div) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA pixel timing: HCLK/2 pixel tick, h/v counters, registered HSYNC/VSYNC/RGB one tick behind.
// Define VGA_BORDER_EN to force a green frame on the outermost visible rows/columns.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic [RGB_W-1:0] pix_data,
  output logic             pix_en,
  output logic             pix_req,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             frame_start,
  output logic             HSYNC,
  output logic             VSYNC,
  output logic [RGB_W-1:0] RGB
);

  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam cnt_t H_ACT_C  = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACT_C  = cnt_t'(V_ACTIVE);
  localparam cnt_t H_LAST_V = cnt_t'(H_ACTIVE - 1);
  localparam cnt_t V_LAST_V = cnt_t'(V_ACTIVE - 1);

  if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_cfg
    $error("vga_timing_gen: line or frame total exceeds counter range");
  end

  cnt_t h_cnt, v_cnt, h_nxt, v_nxt;
  logic h_tc, v_tc_unused, h_sync_win, v_sync_win, v_en;
  logic visible, visible_nxt;
  rgb_t rgb_nxt;

  assign v_en = pix_en & h_tc;

  vga_axis_counter #(
    .TOTAL (H_TOTAL),
    .WIN_LO(H_ACTIVE + H_FP),
    .WIN_HI(H_ACTIVE + H_FP + H_SYNC - 1)
  ) u_h_cnt (
    .clk_div(HCLK),
    .rst    (HRESET),
    .en     (pix_en),
    .cnt    (h_cnt),
    .cnt_nxt(h_nxt),
    .tc     (h_tc),
    .in_win (h_sync_win)
  );

  // The vertical wrap needs no external help, so its terminal count is not consumed.
  vga_axis_counter #(
    .TOTAL (V_TOTAL),
    .WIN_LO(V_ACTIVE + V_FP),
    .WIN_HI(V_ACTIVE + V_FP + V_SYNC - 1)
  ) u_v_cnt (
    .clk_div(HCLK),
    .rst    (HRESET),
    .en     (v_en),
    .cnt    (v_cnt),
    .cnt_nxt(v_nxt),
    .tc     (v_tc_unused),
    .in_win (v_sync_win)
  );

  assign pix_x       = h_cnt;
  assign pix_y       = v_cnt;
  assign visible     = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
  assign visible_nxt = (h_nxt < H_ACT_C) && (v_nxt < V_ACT_C);
  assign frame_start = pix_en && (h_cnt == '0) && (v_cnt == '0);

  always_comb begin
    rgb_nxt = '0;
    if (visible) begin
`ifdef VGA_BORDER_EN
      if (h_cnt == '0 || h_cnt == H_LAST_V || v_cnt == '0 || v_cnt == V_LAST_V)
        rgb_nxt = BORDER_RGB;
      else
        rgb_nxt = pix_data;
`else
      rgb_nxt = pix_data;
`endif
    end
  end

  // pix_req is registered from the post-edge coordinate so it reads 0 while in reset.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pix_en  <= 1'b0;
      pix_req <= 1'b0;
      HSYNC   <= 1'b1;
      VSYNC   <= 1'b1;
      RGB     <= '0;
    end else begin
      pix_en  <= ~pix_en;
      pix_req <= visible_nxt;
      if (pix_en) begin
        HSYNC <= ~h_sync_win;
        VSYNC <= ~v_sync_win;
        RGB   <= rgb_nxt;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a reduced raster (30x15 ticks) with a tick-count model.
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 4, HS = 6, HB = 4;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;

  logic       HCLK, HRESET;
  logic [7:0] pix_data;
  logic       pix_en, pix_req, frame_start, HSYNC, VSYNC;
  logic [9:0] pix_x, pix_y;
  logic [7:0] RGB;

  logic [7:0] fb [HA*VA];

  int vectors = 0;
  int errors  = 0;
  int k = 0;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .pix_data   (pix_data),
    .pix_en     (pix_en),
    .pix_req    (pix_req),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .frame_start(frame_start),
    .HSYNC      (HSYNC),
    .VSYNC      (VSYNC),
    .RGB        (RGB)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t k=%0d",
               nm, act, act, exp, exp, $time, k);
    end
  endtask

  // Frame-buffer emulation: valid data only for the edge that samples it, junk otherwise.
  always @(negedge HCLK) begin
    if (pix_en === 1'b1 && pix_x < 10'(HA) && pix_y < 10'(VA))
      pix_data = fb[int'(pix_y) * HA + int'(pix_x)];
    else
      pix_data = 8'($urandom);
  end

  // Model: after k edges since reset there have been k/2 counter advances.
  int prev_hs, prev_vs, last_hs_fall, last_vs_fall, last_fs, hs_in_frame;

  always @(posedge HCLK) begin
    int n, p, h, v, q, qh, qv;
    int e_en, e_req, e_fs, e_hs, e_vs, e_rgb, on_b;
    if (HRESET) k = 0;
    else k++;
    #1;
    n = k / 2;
    p = n % FR;
    h = p % HT;
    v = p / HT;
    e_en  = k % 2;
    e_req = (k > 0 && h < HA && v < VA) ? 1 : 0;
    e_fs  = (e_en == 1 && p == 0) ? 1 : 0;
    if (n == 0) begin
      e_hs = 1; e_vs = 1; e_rgb = 0;
    end else begin
      q  = (n - 1) % FR;
      qh = q % HT;
      qv = q / HT;
      e_hs = (qh >= HA + HF && qh < HA + HF + HS) ? 0 : 1;
      e_vs = (qv >= VA + VF && qv < VA + VF + VS) ? 0 : 1;
`ifdef VGA_BORDER_EN
      on_b = (qh == 0 || qh == HA - 1 || qv == 0 || qv == VA - 1) ? 1 : 0;
`else
      on_b = 0;
`endif
      if (qh < HA && qv < VA) e_rgb = on_b ? 8'h1c : int'(fb[qv * HA + qh]);
      else e_rgb = 0;
    end
    chk("pix_en", pix_en, e_en);
    chk("pix_req", pix_req, e_req);
    chk("pix_x", pix_x, h);
    chk("pix_y", pix_y, v);
    chk("frame_start", frame_start, e_fs);
    chk("HSYNC", HSYNC, e_hs);
    chk("VSYNC", VSYNC, e_vs);
    chk("RGB", RGB, e_rgb);

    // Hand-computed timing pins for the 30x15 raster (HCLK edges since release).
    if (k == 0) begin
      prev_hs = 1; prev_vs = 1;
      last_hs_fall = -1; last_vs_fall = -1; last_fs = -1; hs_in_frame = 0;
    end else begin
      if (prev_hs == 1 && HSYNC == 1'b0) begin
        if (last_hs_fall < 0) chk("first_hsync_fall_edge", k, 42);
        else chk("line_period", k - last_hs_fall, 60);
        last_hs_fall = k;
        hs_in_frame++;
      end
      if (prev_hs == 0 && HSYNC == 1'b1 && last_hs_fall >= 0)
        chk("hsync_low_time", k - last_hs_fall, 12);
      if (prev_vs == 1 && VSYNC == 1'b0) begin
        chk("vsync_fall_with_hsync_high", HSYNC, 1);
        last_vs_fall = k;
      end
      if (prev_vs == 0 && VSYNC == 1'b1 && last_vs_fall >= 0)
        chk("vsync_low_time", k - last_vs_fall, 120);
      if (frame_start == 1'b1) begin
        if (last_fs >= 0) begin
          chk("frame_period", k - last_fs, 900);
          chk("hsync_pulses_per_frame", hs_in_frame, 15);
        end
        last_fs = k;
        hs_in_frame = 0;
      end
      prev_hs = HSYNC;
      prev_vs = VSYNC;
    end
  end

  task automatic wait_pos(input int wh, input int wv);
    int i;
    for (i = 0; i < 2000; i++) begin
      @(negedge HCLK);
      if (pix_x == 10'(wh) && pix_y == 10'(wv)) break;
    end
    if (i == 2000) chk("wait_position_timeout", 0, 1);
  endtask

  task automatic reset_pulse();
    HRESET = 1'b1;
    @(negedge HCLK);
    HRESET = 1'b0;
    chk("rst_pix_x", pix_x, 0);
    chk("rst_pix_y", pix_y, 0);
    chk("rst_hsync", HSYNC, 1);
    chk("rst_vsync", VSYNC, 1);
    chk("rst_rgb", RGB, 0);
    chk("rst_pix_en", pix_en, 0);
    @(negedge HCLK);
    chk("post_rst_pix_en", pix_en, 1);
    chk("post_rst_frame_start", frame_start, 1);
  endtask

  initial begin
    for (int i = 0; i < HA * VA; i++) fb[i] = 8'($urandom);
    HRESET = 1'b1;
    repeat (10) @(negedge HCLK);
    chk("reset_pix_en", pix_en, 0);
    chk("reset_pix_req", pix_req, 0);
    chk("reset_frame_start", frame_start, 0);
    chk("reset_hsync", HSYNC, 1);
    chk("reset_vsync", VSYNC, 1);
    chk("reset_rgb", RGB, 0);
    HRESET = 1'b0;
    @(negedge HCLK);
    chk("first_tick_pix_en", pix_en, 1);
    chk("first_tick_frame_start", frame_start, 1);
    repeat (2000) @(negedge HCLK);

    wait_pos(10, 5);
    reset_pulse();
    repeat (1900) @(negedge HCLK);

    wait_pos(int'($urandom_range(0, HT - 1)), int'($urandom_range(0, VT - 1)));
    reset_pulse();
    repeat (1000) @(negedge HCLK);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Pixel-timing and sync generator for the AHB VGA peripheral: produces HSYNC, VSYNC and the 8-bit RGB stream that the VGA monitor and the external DAC consume. It derives a pixel tick at HCLK/2, runs horizontal and vertical counters, and requests pixel data from the upstream frame buffer or text generator by coordinate. It also blanks RGB outside the visible area. It sits between the VGA frame buffer and the pins, directly upstream of the VGA monitor.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (ticks)
- H_SYNC, 96, HSYNC pulse width (ticks)
- H_BP, 48, horizontal back porch (ticks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, VSYNC pulse width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- HCLK  in  1  system clock; the only clock
- HRESET  in  1  synchronous, active-high reset
- pix_data  in  8  pixel colour for the coordinate requested on the previous tick
- pix_en  out  1  pixel tick, high every second HCLK cycle
- pix_req  out  1  high while (pix_x, pix_y) lies in the visible area
- pix_x  out  10  horizontal counter value
- pix_y  out  10  vertical counter value
- frame_start  out  1  one-HCLK pulse on the tick where pix_x=0 and pix_y=0
- HSYNC  out  1  horizontal sync, active low
- VSYNC  out  1  vertical sync, active low
- RGB  out  8  {R[2:0],G[2:0],B[1:0]}, 0 when blanked

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Counters are 10 bits. Parameters must satisfy totals ≤ 1024.
- pix_en is a toggle flop. It is 0 in reset and 1 on the first HCLK edge after HRESET falls, then alternates.
- Stage 0 (counters) advances only on edges where pix_en=1:
  - h_cnt wraps H_TOTAL-1 → 0.
  - On that wrap, v_cnt increments and wraps V_TOTAL-1 → 0.
- pix_x=h_cnt and pix_y=v_cnt are direct register outputs.
- pix_req = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- frame_start = pix_en && h_cnt==0 && v_cnt==0.
- Stage 1 (output registers) updates on the same pix_en edges, from the stage-0 values current at that edge:
  - HSYNC = !(h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]), i.e. [656,751].
  - VSYNC = !(v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]), i.e. [490,491].
  - RGB = pix_req ? pix_data : 8'h00.
- Upstream handshake: pix_data must be stable on the pix_en edge that follows the presentation of (pix_x, pix_y), which gives a two-HCLK lookup window. There is no stall or back-pressure; timing is free-running.
- VSYNC changes only on ticks where HSYNC is high, because h_cnt=0 is outside the HSYNC window.

## Timing
- Reset values: h_cnt=0, v_cnt=0, pix_en=0, pix_req=0, frame_start=0, HSYNC=1, VSYNC=1, RGB=0.
- Latency from coordinate to RGB/HSYNC/VSYNC is one pixel tick (2 HCLK). All three outputs are mutually aligned.
- Line period is 1600 HCLK. Frame period is 840000 HCLK.
- HSYNC low time is 192 HCLK. VSYNC low time is 2 lines = 3200 HCLK.
- First HSYNC falling edge: on the 657th pix_en edge after reset release.
- Reset mid-frame: on the next HCLK edge all registers take their reset values. The next frame starts at (0,0) with frame_start on the first tick.
- The simultaneous h and v wrap at (799,524) → (0,0) happens on a single tick, and frame_start asserts on the following tick.

## Configuration
- VGA_BORDER_EN defined: at stage 1, visible pixels with h_cnt ∈ {0, H_ACTIVE-1} or v_cnt ∈ {0, V_ACTIVE-1} output RGB=8'h1c (green) regardless of pix_data. pix_req is unchanged.
- VGA_BORDER_EN undefined: RGB passes pix_data unmodified in the visible area.

## Structure
- Shared package vga_pkg holds:
  - default timing constants (640x480@60 values above)
  - the counter width, 10
  - the RGB width, 8
  - the border colour constant, 8'h1c
  - a typedef for an RGB pixel
- One sub-module, vga_axis_counter: a parameterised wrapping counter with enable, terminal-count output and window-compare output. It is instantiated once for h and once for v; v is enabled by the h terminal count ANDed with pix_en.
- Sync/RGB registers and pix_en stay in the top module.

## Test plan
- Reset held 10 cycles, then released → all outputs at reset values during reset; pix_en=1 on first edge after release; frame_start pulse on that first tick.
- Free run for one frame → 525 HSYNC low pulses of 192 HCLK each; one VSYNC low pulse of 3200 HCLK; 840000 HCLK between frame_start pulses.
- pix_data driven as pix_x[7:0] with one-tick lookup → RGB equals the previous tick's pix_x[7:0] inside the visible area; RGB=0 for h ≥ 640 or v ≥ 480.
- pix_data held at 8'hff, VGA_BORDER_EN defined → RGB=8'h1c on rows 0 and 479 and on columns 0 and 639; 8'hff elsewhere in the visible area. Undefined → 8'hff everywhere in the visible area.
- HRESET pulsed for one cycle at (h=300, v=200) → next tick shows pix_x=0, pix_y=0, HSYNC=VSYNC=1, RGB=0; the following frame timing is identical to the post-reset frame.
- Check across line 489→490 → VSYNC falls only on a tick with HSYNC=1; the h=799/v=524 wrap reaches (0,0) in a single tick.
